// File: rtl/ab_feeder_checker_pkg.sv
// Shared definitions for the operand feeder / result checker.
// Holds the state encoding, the LFSR step and a saturating counter helper.
package ab_feeder_checker_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START_P = 3'd1;
  localparam logic [2:0] S_FEED    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_FAIL    = 3'd5;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  // Galois right-shift step; tx and chk generators must use the same one.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ab_feeder_checker_lfsr16.sv
// 16-bit Galois LFSR with synchronous reload; load has priority over step.
module lfsr16
  import ab_feeder_checker_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/ab_feeder_checker.sv
// Operand feeder and in-order result checker for the multiplier pipeline.
// tx LFSR supplies {A,B}; an identical chk LFSR regenerates pairs to check each X.
module ab_feeder_checker
  import ab_feeder_checker_pkg::*;
#(
  parameter int          BLOCK_LEN   = 16,
  parameter int          NUM_BLOCKS  = 1,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        GO,
  input  logic        REQ_AB,
  input  logic [15:0] X,
  input  logic        X_VALID,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic        ACK,
  output logic        START,
  output logic        HALT,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic [15:0] ERR_CNT,
  output logic [15:0] RES_CNT
);

  localparam int             CW          = $clog2(BLOCK_LEN + 1);
  localparam int             IW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]  BLOCK_LEN_C = CW'(BLOCK_LEN);
  localparam logic [IW-1:0]  IDLE_MAX    = IW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     LAST_BLK    = 8'(NUM_BLOCKS - 1);

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] ack_cnt_reg;
  logic [CW-1:0] blk_res_cnt_reg;
  logic [7:0]    blk_cnt_reg;
  logic [IW-1:0] idle_cnt_reg, idle_cnt_next;
  logic [15:0]   err_cnt_reg;
  logic [15:0]   res_cnt_reg;
  logic          timeout_reg;

  logic [15:0] tx_q, chk_q;
  logic [15:0] exp_prod;
  logic        run_state, wait_state, idle_state;
  logic        ack_w, go_ok, res_accept, res_bad, drain_done, halt_w, new_block;

  assign run_state  = (state_reg == S_START_P) || (state_reg == S_FEED) || (state_reg == S_DRAIN);
  assign wait_state = (state_reg == S_FEED) || (state_reg == S_DRAIN);
  assign idle_state = (state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_FAIL);

  assign ack_w      = (state_reg == S_FEED) && REQ_AB && (ack_cnt_reg < BLOCK_LEN_C);
  assign go_ok      = GO && idle_state;
  assign exp_prod   = {8'd0, chk_q[15:8]} * {8'd0, chk_q[7:0]};
  assign res_accept = X_VALID && run_state && (blk_res_cnt_reg < BLOCK_LEN_C);
  // Results outside a block window count as errors without consuming a chk pair.
  assign res_bad    = (res_accept && (X != exp_prod)) || (X_VALID && !res_accept);
  assign drain_done = (state_reg == S_DRAIN) && (blk_res_cnt_reg == BLOCK_LEN_C);
  assign halt_w     = wait_state && !drain_done && !ack_w && !X_VALID && (idle_cnt_reg == IDLE_MAX);

  always_comb begin
    state_next = state_reg;
    new_block  = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE, S_FAIL: begin
        if (GO) state_next = S_START_P;
      end
      S_START_P: state_next = S_FEED;
      S_FEED: begin
        if (halt_w) state_next = S_FAIL;
        else if (ack_cnt_reg == BLOCK_LEN_C) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done) begin
          if (blk_cnt_reg == LAST_BLK) begin
            state_next = S_DONE;
          end else begin
            state_next = S_START_P;
            new_block  = 1'b1;
          end
        end else if (halt_w) begin
          state_next = S_FAIL;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    idle_cnt_next = '0;
    if (ack_w || X_VALID || (state_next != state_reg)) idle_cnt_next = '0;
    else if (wait_state) idle_cnt_next = idle_cnt_reg + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= S_IDLE;
      ack_cnt_reg     <= '0;
      blk_res_cnt_reg <= '0;
      blk_cnt_reg     <= '0;
      idle_cnt_reg    <= '0;
      err_cnt_reg     <= '0;
      res_cnt_reg     <= '0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;

      if (go_ok || new_block) ack_cnt_reg <= '0;
      else if (ack_w) ack_cnt_reg <= ack_cnt_reg + 1'b1;

      if (go_ok || new_block) blk_res_cnt_reg <= '0;
      else if (res_accept) blk_res_cnt_reg <= blk_res_cnt_reg + 1'b1;

      if (go_ok) blk_cnt_reg <= '0;
      else if (new_block) blk_cnt_reg <= blk_cnt_reg + 8'd1;

      if (go_ok) err_cnt_reg <= '0;
      else if (res_bad) err_cnt_reg <= sat_inc(err_cnt_reg);

      if (go_ok) res_cnt_reg <= '0;
      else if (res_accept) res_cnt_reg <= sat_inc(res_cnt_reg);

      if (go_ok) timeout_reg <= 1'b0;
      else if (halt_w) timeout_reg <= 1'b1;
    end
  end

  lfsr16 #(.RESET_VAL(SEED)) u_tx_lfsr (
    .CLK      (CLK),
    .RST      (RST),
    .load     (go_ok),
    .load_val (SEED),
    .step     (ack_w),
    .q        (tx_q)
  );

  lfsr16 #(.RESET_VAL(SEED)) u_chk_lfsr (
    .CLK      (CLK),
    .RST      (RST),
    .load     (go_ok),
    .load_val (SEED),
    .step     (res_accept),
    .q        (chk_q)
  );

  assign A       = tx_q[15:8];
  assign B       = tx_q[7:0];
  assign ACK     = ack_w;
  assign START   = (state_reg == S_START_P);
  assign HALT    = halt_w;
  assign BUSY    = run_state;
  assign DONE    = (state_reg == S_DONE);
  assign TIMEOUT = timeout_reg;
  assign ERR_CNT = err_cnt_reg;
  assign RES_CNT = res_cnt_reg;

endmodule

// File: tb/tb_ab_feeder_checker.sv
// Directed bench: three instances (default, short timeout, two blocks) driven
// by a behavioural multiplier that answers every ACK with A*B.
module tb_ab_feeder_checker;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst [3];
  logic        go  [3];
  logic        req [3];
  logic        xv  [3];
  logic [15:0] x   [3];
  logic [7:0]  a   [3];
  logic [7:0]  b   [3];
  logic        ack [3];
  logic        start [3];
  logic        halt  [3];
  logic        busy  [3];
  logic        done  [3];
  logic        tmo   [3];
  logic [15:0] err   [3];
  logic [15:0] res   [3];

  logic [15:0] tx_model [3];
  logic [15:0] pair_log [64];
  int n_checks = 0;
  int n_fail   = 0;

  ab_feeder_checker u0 (
    .CLK(CLK), .RST(rst[0]), .GO(go[0]), .REQ_AB(req[0]), .X(x[0]), .X_VALID(xv[0]),
    .A(a[0]), .B(b[0]), .ACK(ack[0]), .START(start[0]), .HALT(halt[0]), .BUSY(busy[0]),
    .DONE(done[0]), .TIMEOUT(tmo[0]), .ERR_CNT(err[0]), .RES_CNT(res[0])
  );

  ab_feeder_checker #(.TIMEOUT_CYC(8)) u1 (
    .CLK(CLK), .RST(rst[1]), .GO(go[1]), .REQ_AB(req[1]), .X(x[1]), .X_VALID(xv[1]),
    .A(a[1]), .B(b[1]), .ACK(ack[1]), .START(start[1]), .HALT(halt[1]), .BUSY(busy[1]),
    .DONE(done[1]), .TIMEOUT(tmo[1]), .ERR_CNT(err[1]), .RES_CNT(res[1])
  );

  ab_feeder_checker #(.NUM_BLOCKS(2)) u2 (
    .CLK(CLK), .RST(rst[2]), .GO(go[2]), .REQ_AB(req[2]), .X(x[2]), .X_VALID(xv[2]),
    .A(a[2]), .B(b[2]), .ACK(ack[2]), .START(start[2]), .HALT(halt[2]), .BUSY(busy[2]),
    .DONE(done[2]), .TIMEOUT(tmo[2]), .ERR_CNT(err[2]), .RES_CNT(res[2])
  );

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] m_prod(input logic [15:0] s);
    return {8'h00, s[15:8]} * {8'h00, s[7:0]};
  endfunction

  task automatic start_run(input int k);
    @(negedge CLK);
    go[k] = 1'b1;
    tx_model[k] = 16'hACE1;
    @(negedge CLK);
    go[k] = 1'b0;
    #1;
    n_checks++;
    if ({start[k], busy[k]} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_pulse u%0d: got start=%b busy=%b expected 1 1", k, start[k], busy[k]);
    end
  endtask

  // Multiplier model: REQ_AB falls one cycle late, one result per cycle, in order.
  task automatic drive_run(input int k, input int npairs, input int stop_acks, input int max_cyc,
                           output int acks, output int sent, output int starts);
    int acks_lag;
    int cyc;
    acks = 0; sent = 0; starts = 0; acks_lag = 0; cyc = 0;
    while (cyc < max_cyc && !(acks == npairs && sent == npairs) && !(stop_acks > 0 && acks >= stop_acks)) begin
      @(negedge CLK);
      cyc++;
      req[k] = (acks_lag < npairs);
      acks_lag = acks;
      if (sent < acks) begin
        xv[k] = 1'b1;
        x[k]  = m_prod(pair_log[sent]);
        sent++;
      end else begin
        xv[k] = 1'b0;
        x[k]  = 16'h0000;
      end
      #1;
      if (start[k] === 1'b1) starts++;
      if (ack[k] === 1'b1) begin
        n_checks++;
        if ({a[k], b[k]} !== tx_model[k]) begin
          n_fail++;
          $display("FAIL pair%0d u%0d: got %h expected %h", acks, k, {a[k], b[k]}, tx_model[k]);
        end
        pair_log[acks] = {a[k], b[k]};
        tx_model[k] = m_step(tx_model[k]);
        acks++;
      end
    end
    n_checks++;
    if (cyc >= max_cyc) begin
      n_fail++;
      $display("FAIL drive_budget u%0d: got acks=%0d sent=%0d expected %0d each", k, acks, sent, npairs);
    end
    @(negedge CLK);
    req[k] = 1'b0;
    xv[k]  = 1'b0;
    x[k]   = 16'h0000;
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 16 && done[k] !== 1'b1; i++) begin
      @(negedge CLK);
      #1;
    end
    n_checks++;
    if ({done[k], busy[k]} !== 2'b10) begin
      n_fail++;
      $display("FAIL done_state u%0d: got done=%b busy=%b expected 1 0", k, done[k], busy[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; go[k] = 1'b0; req[k] = 1'b0; xv[k] = 1'b0; x[k] = 16'h0000;
    end
    repeat (3) @(negedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({ack[k], start[k], halt[k], busy[k], done[k], tmo[k]} !== 6'b000000 || err[k] !== 16'h0 || res[k] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_flags u%0d: got ack=%b start=%b halt=%b busy=%b done=%b tmo=%b err=%h res=%h expected all 0",
                 k, ack[k], start[k], halt[k], busy[k], done[k], tmo[k], err[k], res[k]);
      end
      n_checks++;
      if ({a[k], b[k]} !== 16'hACE1) begin
        n_fail++;
        $display("FAIL reset_ab u%0d: got %h expected ace1", k, {a[k], b[k]});
      end
      rst[k] = 1'b0;
    end
  endtask

  task automatic test_single_block();
    int acks, sent, starts;
    start_run(0);
    drive_run(0, 16, 0, 200, acks, sent, starts);
    n_checks++;
    if (pair_log[0] !== 16'hACE1 || pair_log[1] !== 16'hE270) begin
      n_fail++;
      $display("FAIL first_pairs: got %h %h expected ace1 e270", pair_log[0], pair_log[1]);
    end
    n_checks++;
    if (m_prod(pair_log[0]) !== 16'h972C) begin
      n_fail++;
      $display("FAIL first_x: got %h expected 972c", m_prod(pair_log[0]));
    end
    n_checks++;
    if (acks !== 16 || starts !== 0) begin
      n_fail++;
      $display("FAIL single_acks: got acks=%0d extra_starts=%0d expected 16 0", acks, starts);
    end
    wait_done(0);
    n_checks++;
    if (res[0] !== 16'd16 || err[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL single_counts: got res=%0d err=%0d expected 16 0", res[0], err[0]);
    end
  endtask

  task automatic test_over_request_corrupt();
    int cnt = 0;
    start_run(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      req[0] = 1'b1;
      #1;
      if (ack[0] === 1'b1) begin
        pair_log[cnt] = {a[0], b[0]};
        cnt++;
      end
    end
    @(negedge CLK);
    req[0] = 1'b0;
    #1;
    n_checks++;
    if (cnt !== 16 || pair_log[0] !== 16'hACE1) begin
      n_fail++;
      $display("FAIL over_req_acks: got acks=%0d first=%h expected 16 ace1", cnt, pair_log[0]);
    end
    n_checks++;
    if ({busy[0], done[0], ack[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL over_req_drain: got busy=%b done=%b ack=%b expected 1 0 0", busy[0], done[0], ack[0]);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      xv[0] = 1'b1;
      x[0]  = m_prod(pair_log[i]) ^ ((i == 2) ? 16'h0001 : 16'h0000);
    end
    @(negedge CLK);
    xv[0] = 1'b0;
    x[0]  = 16'h0000;
    #1;
    wait_done(0);
    n_checks++;
    if (err[0] !== 16'd1 || res[0] !== 16'd16) begin
      n_fail++;
      $display("FAIL corrupt_counts: got err=%0d res=%0d expected 1 16", err[0], res[0]);
    end
    @(negedge CLK);
    xv[0] = 1'b1;
    x[0]  = 16'h1234;
    @(negedge CLK);
    xv[0] = 1'b0;
    x[0]  = 16'h0000;
    #1;
    n_checks++;
    if (err[0] !== 16'd2 || res[0] !== 16'd16 || done[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL extra_result: got err=%0d res=%0d done=%b expected 2 16 1", err[0], res[0], done[0]);
    end
  endtask

  task automatic test_stall();
    int acks, sent, starts;
    logic halt_early = 1'b0;
    start_run(1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      #1;
      if (i < 8 && halt[1] !== 1'b0) halt_early = 1'b1;
      if (i == 8) begin
        n_checks++;
        if (halt[1] !== 1'b1 || halt_early !== 1'b0) begin
          n_fail++;
          $display("FAIL halt_timing: got halt=%b early=%b expected 1 0", halt[1], halt_early);
        end
      end
    end
    @(negedge CLK);
    #1;
    n_checks++;
    if ({tmo[1], busy[1], done[1], halt[1]} !== 4'b1000) begin
      n_fail++;
      $display("FAIL fail_state: got tmo=%b busy=%b done=%b halt=%b expected 1 0 0 0", tmo[1], busy[1], done[1], halt[1]);
    end
    start_run(1);
    n_checks++;
    if (tmo[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b expected 0", tmo[1]);
    end
    drive_run(1, 16, 0, 200, acks, sent, starts);
    wait_done(1);
    n_checks++;
    if (res[1] !== 16'd16 || err[1] !== 16'd0 || tmo[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_run: got res=%0d err=%0d tmo=%b expected 16 0 0", res[1], err[1], tmo[1]);
    end
  endtask

  task automatic test_back_to_back_blocks();
    int acks, sent, starts;
    logic [15:0] s17 = 16'hACE1;
    start_run(2);
    drive_run(2, 32, 0, 400, acks, sent, starts);
    for (int i = 0; i < 16; i++) s17 = m_step(s17);
    n_checks++;
    if (pair_log[16] !== s17 || starts !== 1 || acks !== 32) begin
      n_fail++;
      $display("FAIL block2_seq: got pair17=%h starts=%0d acks=%0d expected %h 1 32", pair_log[16], starts, acks, s17);
    end
    wait_done(2);
    n_checks++;
    if (res[2] !== 16'd32 || err[2] !== 16'd0) begin
      n_fail++;
      $display("FAIL two_block_counts: got res=%0d err=%0d expected 32 0", res[2], err[2]);
    end
    start_run(2);
    drive_run(2, 32, 20, 400, acks, sent, starts);
    #1;
    n_checks++;
    if (res[2] !== 16'(sent) || busy[2] !== 1'b1 || starts !== 1) begin
      n_fail++;
      $display("FAIL mid_block2: got res=%0d busy=%b starts=%0d expected %0d 1 1", res[2], busy[2], starts, sent);
    end
    rst[2] = 1'b1;
    @(negedge CLK);
    #1;
    n_checks++;
    if ({ack[2], start[2], halt[2], busy[2], done[2], tmo[2]} !== 6'b000000 || err[2] !== 16'h0 ||
        res[2] !== 16'h0 || {a[2], b[2]} !== 16'hACE1) begin
      n_fail++;
      $display("FAIL mid_run_reset: got busy=%b halt=%b err=%h res=%h ab=%h expected 0 0 0 0 ace1",
               busy[2], halt[2], err[2], res[2], {a[2], b[2]});
    end
    rst[2] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_over_request_corrupt();
    test_stall();
    test_back_to_back_blocks();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ab_feeder_checker.md
Name: ab_feeder_checker

Overview:
- Far end of the multiplier block's operand/result interface.
- Answers REQ_AB with ACK and an operand pair {A,B}, issues START (and HALT on stall), and collects X on X_VALID.
- Operands come from a 16-bit LFSR. A second identical LFSR regenerates the expected pairs, so each X is checked against A*B in arrival order.
- Used as the stimulus/checker front end for the multiplier pipeline on the evaluation board and in system simulation.

Parameters:
- BLOCK_LEN, 16, operand pairs per START; equals the multiplier's input FIFO depth.
- NUM_BLOCKS, 1, blocks per GO run; 1..255.
- SEED, 16'hACE1, LFSR seed, must be nonzero; A = state[15:8], B = state[7:0].
- TIMEOUT_CYC, 1024, idle cycles allowed in FEED/DRAIN before abort.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- GO  in  1  one-cycle run request; sampled only in IDLE/DONE/FAIL
- REQ_AB  in  1  operand request level from multiplier (registered at its end)
- X  in  16  result
- X_VALID  in  1  result strobe, one result per high cycle
- A  out  8  operand A = tx_lfsr[15:8]
- B  out  8  operand B = tx_lfsr[7:0]
- ACK  out  1  operand-valid strobe; A/B valid in the same cycle
- START  out  1  one-cycle start pulse to multiplier
- HALT  out  1  one-cycle abort pulse to multiplier
- BUSY  out  1  high in START_P/FEED/DRAIN
- DONE  out  1  high in DONE state
- TIMEOUT  out  1  sticky stall flag; cleared by GO or RST
- ERR_CNT  out  16  mismatch/unexpected-result count, saturating
- RES_CNT  out  16  results received this run, saturating

Behaviour:
- Reset:
  - State IDLE; both LFSRs = SEED.
  - ACK, START, HALT, DONE, BUSY, TIMEOUT = 0; ERR_CNT = RES_CNT = 0; block, ack and result counters = 0.
  - RST mid-run aborts immediately with the same values. HALT is not pulsed.
- States and transitions:
  - IDLE: GO -> START_P. GO also clears counters and TIMEOUT and reloads SEED into both LFSRs.
  - START_P: START = 1 for exactly one cycle -> FEED.
  - FEED: ACK = REQ_AB && (ack_cnt < BLOCK_LEN), combinational from the registered state.
    - Each ACK advances tx_lfsr and ack_cnt at the clock edge.
    - ack_cnt == BLOCK_LEN -> DRAIN. No further ACK is issued even if REQ_AB is still high; REQ_AB falls one cycle late, and that cycle must not produce an ACK.
  - DRAIN: wait until blk_res_cnt == BLOCK_LEN.
    - If blocks remaining -> START_P, with blk counters cleared and LFSRs not reseeded.
    - Otherwise -> DONE.
  - DONE: DONE = 1; GO -> START_P (new run, reseeded).
  - FAIL: entered on timeout; TIMEOUT = 1; GO -> START_P (new run).
- Result path, active in every state:
  - On X_VALID: exp = chk_lfsr[15:8] * chk_lfsr[7:0], full 16-bit unsigned product.
  - X != exp -> ERR_CNT++.
  - chk_lfsr advances, RES_CNT++ and blk_res_cnt++.
  - X_VALID while blk_res_cnt == BLOCK_LEN, or in IDLE/DONE/FAIL: ERR_CNT++, chk_lfsr and RES_CNT unchanged.
  - X_VALID is allowed in FEED; results may overlap feeding.
- LFSR: Galois, right shift; next = (s >> 1) ^ (s[0] ? 16'hB400 : 0). Period 65535. The same step is used by tx and chk.
- Timeout:
  - idle_cnt clears on any ACK or X_VALID and on state entry; it increments in FEED/DRAIN otherwise.
  - idle_cnt == TIMEOUT_CYC-1 -> HALT = 1 for one cycle, state -> FAIL.
- Simultaneous events:
  - ACK and X_VALID in the same cycle both take effect.
  - The last result and a timeout in the same cycle: the result wins (idle_cnt cleared).
  - GO while BUSY is ignored.
- Counters saturate at 16'hFFFF.

Decomposition:
- Shared package: state encoding (IDLE, START_P, FEED, DRAIN, DONE, FAIL), LFSR_TAPS = 16'hB400.
- Sub-module lfsr16 (load, load_val, step, q), instantiated twice (tx, chk).
- The multiply for exp is inline.

Test Plan:
- Reset: hold RST 3 cycles -> all outputs 0, A/B = 8'hAC/8'hE1.
- Single block, behavioural multiplier model: GO -> one START pulse; 16 ACKs; first pair 0xAC,0xE1, second 0xE2,0x70; first X 16'h972C accepted; 16 results -> DONE = 1, RES_CNT = 16, ERR_CNT = 0.
- Over-request: REQ_AB held high for 20 cycles in FEED -> exactly 16 ACKs, then DRAIN.
- Corrupt 3rd result (XOR 1) -> ERR_CNT = 1, RES_CNT = 16, DONE. An extra X_VALID after DONE -> ERR_CNT = 2, RES_CNT = 16.
- Stall: REQ_AB held low after START with TIMEOUT_CYC = 8 -> HALT pulse 8 cycles after FEED entry, TIMEOUT = 1, state FAIL. GO restarts with TIMEOUT cleared.
- NUM_BLOCKS = 2 -> two START pulses; the second block's first pair continues the LFSR sequence (17th state); RES_CNT = 32; RST asserted mid second block -> all outputs return to reset values next cycle.
